// File: rtl/updown_button_ctrl.sv
// Pushbutton front end for the 8-bit up/down counter: per-button sync + debounce,
// then a hold/repeat/lockout FSM that emits mutually exclusive one-cycle up/down strobes.

module updown_btn_filter #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // sync[1] is the synchronised sample; level only follows it after a full stable run
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module updown_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic up,
    output logic down,
    output logic busy
);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX);

    typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, LOCK} state_t;

    logic [1:0] raw_v;
    logic [1:0] lvl;
    logic       d_up, d_dn;

    assign raw_v = {btn_down, btn_up};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        updown_btn_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_flt (
            .clock(clock),
            .reset(reset),
            .raw  (raw_v[i]),
            .level(lvl[i])
        );
    end

    assign d_up = lvl[0];
    assign d_dn = lvl[1];

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          up_nx, down_nx;
    logic          own, other;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            up    <= 1'b0;
            down  <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            up    <= up_nx;
            down  <= down_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        up_nx    = 1'b0;
        down_nx  = 1'b0;
        own      = (state == HOLD_UP) ? d_up : d_dn;
        other    = (state == HOLD_UP) ? d_dn : d_up;
        case (state)
            IDLE: begin
                if (d_up && d_dn) begin
                    state_nx = LOCK;
                end else if (d_up) begin
                    up_nx    = 1'b1;
                    timer_nx = TW'(REPEAT_DELAY - 1);
                    state_nx = HOLD_UP;
                end else if (d_dn) begin
                    down_nx  = 1'b1;
                    timer_nx = TW'(REPEAT_DELAY - 1);
                    state_nx = HOLD_DN;
                end
            end
            HOLD_UP, HOLD_DN: begin
                // release beats lockout, lockout beats a due repeat
                if (!own) begin
                    state_nx = IDLE;
                end else if (other) begin
                    state_nx = LOCK;
                end else if (timer == '0) begin
                    if (REPEAT_EN) begin
                        up_nx    = (state == HOLD_UP);
                        down_nx  = (state == HOLD_DN);
                        timer_nx = TW'(REPEAT_PERIOD - 1);
                    end
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            LOCK: begin
                if (!d_up && !d_dn) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_updown_button_ctrl.sv
// Random + directed bench: two DUTs (repeat on/off) against a window/age based model.

module tb_updown_button_ctrl;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clock = 1'b0, reset = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic up, down, busy, up_n, down_n, busy_n;

    updown_button_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .up(up), .down(down), .busy(busy));

    updown_button_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)) dut_nr (
        .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .up(up_n), .down(down_n), .busy(busy_n));

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int s_up = 0, s_dn = 0, s_dnn = 0;
    logic [7:0] count8 = 8'h00;

    // model: raw history window, debounced levels, hold mode and age since first strobe
    logic h_up[D+2], h_dn[D+2];
    logic m_dup, m_ddn;
    int   m_mode, m_age;
    logic [2:0] exp1, exp0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int j = 0; j < D + 2; j++) begin h_up[j] = 1'b0; h_dn[j] = 1'b0; end
        m_dup = 1'b0; m_ddn = 1'b0; m_mode = 0; m_age = 0;
        exp1 = 3'b000; exp0 = 3'b000;
    endtask

    task automatic model_step();
        logic od_up, od_dn, own, other, su, sd, ru, rd;
        bit fu, fd;
        od_up = m_dup; od_dn = m_ddn;
        su = 1'b0; sd = 1'b0; ru = 1'b0; rd = 1'b0;
        for (int j = D + 1; j > 0; j--) begin h_up[j] = h_up[j-1]; h_dn[j] = h_dn[j-1]; end
        h_up[0] = btn_up; h_dn[0] = btn_down;
        // level flips once the D synchronised samples (raw two edges back) all disagree
        fu = 1'b1; fd = 1'b1;
        for (int j = 2; j <= D + 1; j++) begin
            if (h_up[j] == m_dup) fu = 1'b0;
            if (h_dn[j] == m_ddn) fd = 1'b0;
        end
        if (fu) m_dup = ~m_dup;
        if (fd) m_ddn = ~m_ddn;
        case (m_mode)
            0: begin
                if (od_up && od_dn) m_mode = 3;
                else if (od_up) begin m_mode = 1; m_age = 0; su = 1'b1; end
                else if (od_dn) begin m_mode = 2; m_age = 0; sd = 1'b1; end
            end
            1, 2: begin
                own   = (m_mode == 1) ? od_up : od_dn;
                other = (m_mode == 1) ? od_dn : od_up;
                if (!own) m_mode = 0;
                else if (other) m_mode = 3;
                else begin
                    m_age++;
                    if (m_age >= RD && (m_age - RD) % RP == 0) begin
                        if (m_mode == 1) ru = 1'b1; else rd = 1'b1;
                    end
                end
            end
            default: if (!od_up && !od_dn) m_mode = 0;
        endcase
        exp1 = {m_mode != 0, sd | rd, su | ru};
        exp0 = {m_mode != 0, sd, su};
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset(); else model_step();
        cyc++;
        #1;
        chk("out_rep", {busy, down, up}, exp1);
        chk("out_norep", {busy_n, down_n, up_n}, exp0);
        if (up) begin s_up++; count8 = count8 + 8'd1; end
        if (down) begin s_dn++; count8 = count8 - 8'd1; end
        if (down_n) s_dnn++;
    endtask

    task automatic settle();
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (15) tick();
    endtask

    task automatic clr();
        s_up = 0; s_dn = 0; s_dnn = 0;
    endtask

    int pk[$];
    int want2[5] = '{6, 14, 17, 20, 23};
    int t0, first, late, dur;

    initial begin
        model_reset();
        reset = 1'b1;
        repeat (2) tick();
        chk("reset_state", {busy, down, up, busy_n, down_n, up_n}, 6'b0);
        reset = 1'b0;
        repeat (3) tick();

        // async reset mid-cycle while a button is held
        btn_up = 1'b1;
        repeat (8) tick();
        #2 reset = 1'b1;
        #1 chk("rst_async", {busy, down, up, busy_n, down_n, up_n}, 6'b0);
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        clr();
        repeat (6) tick();
        chk("rst_quiet", s_up + s_dn, 0);
        tick();
        chk("rst_first", s_up, 1);
        settle();

        // held up: initial strobe then repeats
        clr(); pk.delete();
        btn_up = 1'b1; t0 = cyc + 1;
        repeat (25) begin tick(); if (up) pk.push_back(cyc - t0); end
        chk("t2_count", pk.size(), 5);
        for (int i = 0; i < 5 && i < pk.size(); i++) chk("t2_edge", pk[i], want2[i]);
        chk("t2_down", s_dn, 0);
        settle();

        // bouncy down press, then a short glitch
        clr();
        foreach (want2[i]) if (i < 4) begin btn_down = (i % 2 == 0); tick(); end
        btn_down = 1'b1; t0 = cyc + 1; first = -1;
        repeat (10) begin tick(); if (down && first < 0) first = cyc - t0; end
        chk("t3_once", s_dn, 1);
        chk("t3_lat", first, 6);
        settle();
        clr();
        btn_down = 1'b1; repeat (3) tick();
        btn_down = 1'b0; repeat (12) tick();
        chk("t3_glitch", s_dn, 0);

        // lockout while up held
        clr(); late = 0;
        btn_up = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) btn_down = 1'b1;
            tick();
            if (i >= 15 && (up || down)) late++;
        end
        chk("t4_late", late, 0);
        chk("t4_busy", busy, 1);
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (12) tick();
        chk("t4_idle", busy, 0);

        // no-repeat instance: one strobe per press
        clr();
        btn_down = 1'b1;
        repeat (40) tick();
        chk("t5_norep", s_dnn, 1);
        chk("t5_rep", s_dn, 1 + (39 - 6 - RD) / RP + 1);
        settle();

        // counter driven by the strobes
        count8 = 8'h00;
        repeat (3) begin btn_up = 1'b1; repeat (8) tick(); btn_up = 1'b0; repeat (10) tick(); end
        repeat (5) begin btn_down = 1'b1; repeat (8) tick(); btn_down = 1'b0; repeat (10) tick(); end
        chk("t6_count", count8, 8'hFE);

        // random levels and durations, occasional mid-cycle reset
        repeat (250) begin
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = ($urandom_range(0, 3) == 0);
            dur = $urandom_range(1, 25);
            repeat (dur) tick();
            if ($urandom_range(0, 40) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                repeat (2) tick();
                reset = 1'b0;
            end
        end
        settle();
        chk("end_idle", {busy, busy_n}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
